pixel_array_ctrl: RTL and testbench

- Frame sequencer and readout master for the 4-pixel array. It drives the array's ERASE, EXPOSE and READ1..READ4 controls, plus the ramp enable.
- During conversion it drives the ADC code counter onto the array data buses. During readout it captures each pixel's latched 8-bit code.
- Captured codes go out on a valid/ready stream toward the host-side logic.
- At top level, the array's inout DATAn buses are built from this block's cnt_out/data_oe (drive side) and datan_in (sense side).

---
 rtl/pixel_ctrl_pkg.sv | 23 ++
 rtl/pixel_phase_timer.sv | 36 +++
 rtl/pixel_array_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pixel_array_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_ctrl_pkg.sv
// Shared types and constants for the 4-pixel array frame sequencer.
package pixel_ctrl_pkg;

  localparam int NUM_PIXELS = 4;
  localparam int PIX_IDX_W  = 2;
  localparam int TIMER_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_TURN,
    ST_READ,
    ST_WAIT,
    ST_DONE
  } state_e;

  function automatic logic [NUM_PIXELS-1:0] read_sel_onehot(input logic [PIX_IDX_W-1:0] sel);
    return NUM_PIXELS'(1) << sel;
  endfunction

endpackage

// File: rtl/pixel_phase_timer.sv
// Loadable down-counter that times the ERASE, EXPOSE and READ settle phases.
// tc_o is high in the last cycle of a phase loaded with (duration - 1).
module pixel_phase_timer
  import pixel_ctrl_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer and readout master for the 4-pixel array: erase, expose,
// ramp conversion onto the DATA buses, then per-pixel readout onto a valid/ready stream.
module pixel_array_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int ERASE_CYCLES  = 5,
  parameter int EXPOSE_CYCLES = 255,
  parameter int DATA_W        = 8,
  parameter int READ_SETTLE   = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 frame_start_i,
  output logic                 busy_o,
  output logic                 erase_o,
  output logic                 expose_o,
  output logic                 ramp_en_o,
  output logic                 read1_o,
  output logic                 read2_o,
  output logic                 read3_o,
  output logic                 read4_o,
  output logic [DATA_W-1:0]    cnt_o,
  output logic                 data_oe_o,
  input  logic [DATA_W-1:0]    data1_i,
  input  logic [DATA_W-1:0]    data2_i,
  input  logic [DATA_W-1:0]    data3_i,
  input  logic [DATA_W-1:0]    data4_i,
  output logic [DATA_W-1:0]    pix_data_o,
  output logic [PIX_IDX_W-1:0] pix_idx_o,
  output logic                 pix_valid_o,
  input  logic                 pix_ready_i,
  output logic                 frame_done_o
);

  localparam logic [TIMER_W-1:0]   ERASE_LOAD  = TIMER_W'(ERASE_CYCLES - 1);
  localparam logic [TIMER_W-1:0]   EXPOSE_LOAD = TIMER_W'(EXPOSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0]   SETTLE_LOAD = TIMER_W'(READ_SETTLE - 1);
  localparam logic [DATA_W-1:0]    CONV_LAST   = '1;
  localparam logic [PIX_IDX_W-1:0] LAST_PIX    = PIX_IDX_W'(NUM_PIXELS - 1);

  state_e                  state_q, state_d;
  logic [PIX_IDX_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]       conv_q, conv_d;
  logic [DATA_W-1:0]       pix_data_q, pix_data_d;
  logic [PIX_IDX_W-1:0]    pix_idx_q, pix_idx_d;
  logic                    pix_valid_q, pix_valid_d;

  logic                    busy_q, erase_q, expose_q, ramp_q, oe_q, done_q;
  logic [NUM_PIXELS-1:0]   read_q;

  logic                    tmr_load;
  logic [TIMER_W-1:0]      tmr_val;
  logic                    tmr_tc;

  logic [DATA_W-1:0]       sense [NUM_PIXELS];

  assign sense[0] = data1_i;
  assign sense[1] = data2_i;
  assign sense[2] = data3_i;
  assign sense[3] = data4_i;

  pixel_phase_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  // Every output is a register fed from the next state, so the control
  // pins change exactly on the edge that enters each phase.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    conv_d      = conv_q;
    pix_data_d  = pix_data_q;
    pix_idx_d   = pix_idx_q;
    pix_valid_d = pix_valid_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    case (state_q)
      ST_IDLE: begin
        if (frame_start_i) begin
          state_d  = ST_ERASE;
          tmr_load = 1'b1;
          tmr_val  = ERASE_LOAD;
        end
      end
      ST_ERASE: begin
        if (tmr_tc) begin
          state_d  = ST_EXPOSE;
          tmr_load = 1'b1;
          tmr_val  = EXPOSE_LOAD;
        end
      end
      ST_EXPOSE: begin
        if (tmr_tc) begin
          state_d = ST_CONVERT;
          conv_d  = '0;
        end
      end
      ST_CONVERT: begin
        if (conv_q == CONV_LAST) begin
          state_d = ST_TURN;
          conv_d  = '0;
        end else begin
          conv_d = conv_q + DATA_W'(1);
        end
      end
      ST_TURN: begin
        state_d  = ST_READ;
        sel_d    = '0;
        tmr_load = 1'b1;
        tmr_val  = SETTLE_LOAD;
      end
      ST_READ: begin
        if (tmr_tc) begin
          state_d     = ST_WAIT;
          pix_data_d  = sense[sel_q];
          pix_idx_d   = sel_q;
          pix_valid_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (pix_ready_i) begin
          pix_valid_d = 1'b0;
          if (sel_q == LAST_PIX) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_READ;
            sel_d    = sel_q + PIX_IDX_W'(1);
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LOAD;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      conv_q      <= '0;
      pix_data_q  <= '0;
      pix_idx_q   <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      conv_q      <= conv_d;
      pix_data_q  <= pix_data_d;
      pix_idx_q   <= pix_idx_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  // A READn line stays up through WAIT so the pixel keeps driving its bus
  // until the host takes the code.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_q   <= 1'b0;
      erase_q  <= 1'b0;
      expose_q <= 1'b0;
      ramp_q   <= 1'b0;
      oe_q     <= 1'b0;
      done_q   <= 1'b0;
      read_q   <= '0;
    end else begin
      busy_q   <= (state_d != ST_IDLE);
      erase_q  <= (state_d == ST_ERASE);
      expose_q <= (state_d == ST_EXPOSE);
      ramp_q   <= (state_d == ST_CONVERT);
      oe_q     <= (state_d == ST_CONVERT);
      done_q   <= (state_d == ST_DONE);
      read_q   <= ((state_d == ST_READ) || (state_d == ST_WAIT)) ? read_sel_onehot(sel_d) : '0;
    end
  end

  assign busy_o       = busy_q;
  assign erase_o      = erase_q;
  assign expose_o     = expose_q;
  assign ramp_en_o    = ramp_q;
  assign data_oe_o    = oe_q;
  assign cnt_o        = conv_q;
  assign read1_o      = read_q[0];
  assign read2_o      = read_q[1];
  assign read3_o      = read_q[2];
  assign read4_o      = read_q[3];
  assign pix_data_o   = pix_data_q;
  assign pix_idx_o    = pix_idx_q;
  assign pix_valid_o  = pix_valid_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Self-checking bench for pixel_array_ctrl: timeline reference model of a frame
// plus a pixel stream scoreboard and control-line invariants checked every cycle.
module tb_pixel_array_ctrl;

  localparam int E         = 5;
  localparam int X         = 255;
  localparam int DW        = 8;
  localparam int S         = 2;
  localparam int CONV      = 1 << DW;
  localparam int TURN_OFF  = E + X + CONV;
  localparam int READ_OFF  = TURN_OFF + 1;
  localparam int FRAME_LEN = E + X + CONV + 1 + 4 * (S + 1) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          frameStart;
  logic          pixReady;
  logic          busy, erase, expose, rampEn, dataOe, pixValid, frameDone;
  logic          read1, read2, read3, read4;
  logic [DW-1:0] cntOut, pixData;
  logic [1:0]    pixIdx;
  logic [DW-1:0] data1, data2, data3, data4;
  logic [3:0]    readVec;

  logic [DW-1:0] codes [4];
  int            readyMode;
  int            stallLeft;

  int numChecks = 0;
  int numFails  = 0;

  always #5 clk = ~clk;

  assign readVec = {read4, read3, read2, read1};

  // Behavioural array: a selected pixel drives its code, otherwise the bus
  // carries the ramp code or an idle pattern.
  assign data1 = readVec[0] ? codes[0] : (dataOe ? cntOut : 8'h5A);
  assign data2 = readVec[1] ? codes[1] : (dataOe ? cntOut : 8'h5A);
  assign data3 = readVec[2] ? codes[2] : (dataOe ? cntOut : 8'h5A);
  assign data4 = readVec[3] ? codes[3] : (dataOe ? cntOut : 8'h5A);

  pixel_array_ctrl #(
    .ERASE_CYCLES  (E),
    .EXPOSE_CYCLES (X),
    .DATA_W        (DW),
    .READ_SETTLE   (S)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .frame_start_i (frameStart),
    .busy_o        (busy),
    .erase_o       (erase),
    .expose_o      (expose),
    .ramp_en_o     (rampEn),
    .read1_o       (read1),
    .read2_o       (read2),
    .read3_o       (read3),
    .read4_o       (read4),
    .cnt_o         (cntOut),
    .data_oe_o     (dataOe),
    .data1_i       (data1),
    .data2_i       (data2),
    .data3_i       (data3),
    .data4_i       (data4),
    .pix_data_o    (pixData),
    .pix_idx_o     (pixIdx),
    .pix_valid_o   (pixValid),
    .pix_ready_i   (pixReady),
    .frame_done_o  (frameDone)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model state: a frame is a fixed timeline from its first ERASE
  // cycle up to readout, then one pixel at a time gated by the consumer.
  bit         frameActive = 0;
  bit         startPending = 0;
  bit         wasActive;
  int         cyc = 0;
  int         t0, off, curPix, phaseStart, doneCycle, stalls;
  int         dutStart = 0;
  int         framesSeen = 0;
  logic       prevOe = 0, prevErase = 0;
  logic [3:0] prevRead = '0;
  logic       expErase, expExpose, expOe, expValid, expDone;
  logic [3:0] expRead;
  int         expCnt;

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        frameActive  = 0;
        startPending = 0;
        prevOe       = 0;
        prevErase    = 0;
        prevRead     = '0;
        checkOutput("resetOutputs",
                    {busy, erase, expose, rampEn, readVec, dataOe, frameDone, pixValid, pixIdx, cntOut, pixData},
                    0);
        continue;
      end
      if (startPending) begin
        startPending = 0;
        frameActive  = 1;
        t0           = cyc;
        curPix       = 0;
        phaseStart   = cyc + READ_OFF;
        doneCycle    = -1;
        stalls       = 0;
      end
      wasActive = frameActive;
      expErase = 0; expExpose = 0; expOe = 0; expCnt = 0;
      expRead = '0; expValid = 0; expDone = 0;
      if (frameActive) begin
        off = cyc - t0;
        if (off < E) expErase = 1;
        else if (off < E + X) expExpose = 1;
        else if (off < TURN_OFF) begin
          expOe  = 1;
          expCnt = off - E - X;
        end else if (cyc == doneCycle) expDone = 1;
        else if (cyc >= phaseStart) begin
          expRead  = 4'(1 << curPix);
          expValid = ((cyc - phaseStart) >= S);
        end
      end
      checkOutput("busy", busy, frameActive);
      checkOutput("erase", erase, expErase);
      checkOutput("expose", expose, expExpose);
      checkOutput("dataOe", dataOe, expOe);
      checkOutput("rampEn", rampEn, expOe);
      checkOutput("cntOut", cntOut, expCnt);
      checkOutput("readLines", readVec, expRead);
      checkOutput("pixValid", pixValid, expValid);
      checkOutput("frameDone", frameDone, expDone);
      if (expValid) begin
        checkOutput("pixData", pixData, codes[curPix]);
        checkOutput("pixIdx", pixIdx, curPix);
      end
      checkOutput("ctrlOneHot", $countones({erase, expose, dataOe, readVec}) <= 1, 1);
      checkOutput("turnGap", (dataOe && (readVec != 0 || prevRead != 0)) || (prevOe && readVec != 0), 0);

      if (expValid) begin
        if (pixReady) begin
          if (curPix == 3) doneCycle = cyc + 1;
          else begin
            curPix++;
            phaseStart = cyc + 1;
          end
        end else begin
          stalls++;
        end
      end
      if (erase && !prevErase) begin
        framesSeen++;
        dutStart = cyc;
      end
      if (frameDone) checkOutput("frameLength", cyc - dutStart + 1, FRAME_LEN + stalls);
      if (expDone) frameActive = 0;
      if (!wasActive && frameStart) startPending = 1;
      prevErase = erase;
      prevOe    = dataOe;
      prevRead  = readVec;
    end
  end

  // Consumer: always ready, a 10-cycle stall on pixel 1, or random.
  initial begin : readyDriver
    pixReady = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (readyMode)
        1: begin
          if (pixValid && pixIdx == 2'd1 && stallLeft > 0) begin
            pixReady = 1'b0;
            stallLeft--;
          end else begin
            pixReady = 1'b1;
          end
        end
        2:       pixReady = 1'($urandom_range(0, 1));
        default: pixReady = 1'b1;
      endcase
    end
  end

  task automatic applyStimulus(input int mode, input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                               input logic [DW-1:0] c2, input logic [DW-1:0] c3);
    @(posedge clk);
    #2;
    codes[0]   = c0;
    codes[1]   = c1;
    codes[2]   = c2;
    codes[3]   = c3;
    readyMode  = mode;
    stallLeft  = 10;
    frameStart = 1'b1;
    @(posedge clk);
    #2;
    frameStart = 1'b0;
  endtask

  task automatic pulseStart();
    @(posedge clk);
    #2;
    frameStart = 1'b1;
    @(posedge clk);
    #2;
    frameStart = 1'b0;
  endtask

  task automatic waitFrameEnd(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((busy || frameActive || startPending) && n < 3000);
    checkOutput(tag, busy || frameActive, 0);
  endtask

  function automatic logic [DW-1:0] rndCode();
    return DW'($urandom);
  endfunction

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    int n;
    reset      = 1'b1;
    frameStart = 1'b0;
    readyMode  = 0;
    stallLeft  = 0;
    for (int i = 0; i < 4; i++) codes[i] = '0;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstErase", erase, 0);
    checkOutput("rstExpose", expose, 0);
    checkOutput("rstRamp", rampEn, 0);
    checkOutput("rstRead", readVec, 0);
    checkOutput("rstOe", dataOe, 0);
    checkOutput("rstCnt", cntOut, 0);
    checkOutput("rstPixData", pixData, 0);
    checkOutput("rstPixIdx", pixIdx, 0);
    checkOutput("rstPixValid", pixValid, 0);
    checkOutput("rstFrameDone", frameDone, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    $display("[TB] frame A: fixed codes, consumer always ready");
    applyStimulus(0, 8'h0A, 8'h55, 8'hC3, 8'hFF);
    waitFrameEnd("frameAEnds");

    $display("[TB] frame B: backpressure on pixel 1");
    applyStimulus(1, rndCode(), 8'h55, rndCode(), rndCode());
    waitFrameEnd("frameBEnds");

    $display("[TB] frame C: random ready, frame_start during EXPOSE and DONE");
    applyStimulus(2, rndCode(), rndCode(), rndCode(), rndCode());
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!expose && n < 500);
    checkOutput("reachExpose", expose, 1);
    pulseStart();
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!frameDone && n < 3000);
    checkOutput("reachDone", frameDone, 1);
    frameStart = 1'b1;
    @(posedge clk);
    #2;
    frameStart = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("noRestartAfterDone", busy, 0);

    $display("[TB] frame D: reset during conversion");
    applyStimulus(0, rndCode(), rndCode(), rndCode(), rndCode());
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(dataOe && cntOut == 8'd100) && n < 1000);
    checkOutput("reachCnt100", cntOut, 100);
    reset = 1'b1;
    #1;
    checkOutput("midRstOe", dataOe, 0);
    checkOutput("midRstRamp", rampEn, 0);
    checkOutput("midRstCnt", cntOut, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstRead", readVec, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    checkOutput("idleAfterRst", busy, 0);
    checkOutput("noValidAfterRst", pixValid, 0);

    $display("[TB] frame E: random codes and ready after reset");
    applyStimulus(2, rndCode(), rndCode(), rndCode(), rndCode());
    waitFrameEnd("frameEEnds");

    checkOutput("framesStarted", framesSeen, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
